// File: rtl/json_byte_unpacker.sv
// rtl/json_byte_unpacker.sv - 64-bit beat to byte-stream serialiser feeding the JSON tokenizer
//
// Purpose:
//   Accepts 64-bit beats with a byte-keep mask and a last flag.
//   Emits one byte per cycle, lowest emittable lane first.
//   Flags the final byte of each packet on out_last.
//   Counts completed packets.
//   Sets a sticky error when a last beat carries no emittable lanes.
//
// Configuration macro: JSON_UNPACK_SPARSE_KEEP_EN
//   defined   : every lane with its keep bit set is emitted; holes are skipped.
//   undefined : only the contiguous run of keep bits starting at lane 0 is emitted.
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst            in   synchronous active-high reset
//   in_data        in   beat data, lane i = in_data[8i+7:8i]
//   in_keep        in   lane-valid mask
//   in_last        in   beat ends a packet
//   in_valid       in   upstream beat present
//   in_ready       out  beat accepted when in_valid && in_ready
//   out_byte       out  serialised byte
//   out_last       out  final byte of a packet
//   out_valid      out  byte present
//   out_ready      in   downstream accepts when out_valid && out_ready
//   pkt_count      out  completed packets, wraps
//   err_empty_last out  sticky empty-last-beat error
module json_byte_unpacker #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [7:0]        in_keep,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              err_empty_last
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_DRAIN = 1'b1;

  logic              r_state;
  logic [DATA_W-1:0] r_data;
  logic [7:0]        r_mask;
  logic              r_last;
  logic [CNT_W-1:0]  r_pkt_count;
  logic              r_err;

  logic [7:0] w_emit_mask;
  logic [7:0] w_lowest;
  logic [2:0] w_lane_idx;
  logic       w_single;
  logic       w_in_hs;
  logic       w_out_hs;

`ifdef JSON_UNPACK_SPARSE_KEEP_EN
  assign w_emit_mask = in_keep;
`else
  // Running AND from lane 0: a lane is emittable only while no lower lane is unkept.
  always_comb begin
    logic run;
    run = 1'b1;
    w_emit_mask = '0;
    for (int i = 0; i < 8; i++) begin
      run = run & in_keep[i];
      w_emit_mask[i] = run;
    end
  end
`endif

  // Isolate the lowest set bit of the pending mask; it is the lane on the bus.
  assign w_lowest = r_mask & (~r_mask + 8'd1);
  assign w_single = (r_mask != 8'd0) && ((r_mask & (r_mask - 8'd1)) == 8'd0);

  always_comb begin
    w_lane_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_lane_idx = 3'(i);
      end
    end
  end

  // Outputs come straight from registered state, so they cannot move while stalled.
  // rst forces the idle handshake levels even before the reset edge lands.
  assign out_valid = (r_state == ST_DRAIN) && !rst;
  assign out_byte  = r_data[{w_lane_idx, 3'b000} +: 8];
  assign out_last  = r_last && w_single;
  assign in_ready  = rst || (r_state == ST_EMPTY) || (w_single && out_ready);

  assign w_out_hs = out_valid && out_ready;
  assign w_in_hs  = in_valid && in_ready && !rst;

  assign pkt_count      = r_pkt_count;
  assign err_empty_last = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_data      <= '0;
      r_mask      <= '0;
      r_last      <= 1'b0;
      r_pkt_count <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_out_hs) begin
        r_mask <= r_mask & ~w_lowest;
        if (out_last) begin
          r_pkt_count <= r_pkt_count + 1'b1;
        end
      end
      // An accept in DRAIN only happens alongside the final byte handshake,
      // so loading here safely overrides the mask update above.
      if (w_in_hs) begin
        r_data <= in_data;
        r_mask <= w_emit_mask;
        r_last <= in_last;
        if (w_emit_mask == 8'd0) begin
          r_state <= ST_EMPTY;
          if (in_last) begin
            r_err <= 1'b1;
          end
        end else begin
          r_state <= ST_DRAIN;
        end
      end else if (w_out_hs && w_single) begin
        r_state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_json_byte_unpacker.sv
// tb/tb_json_byte_unpacker.sv - directed self-checking bench for json_byte_unpacker
module tb_json_byte_unpacker;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic [7:0]  in_keep;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pkt_count;
  logic        err_empty_last;

  int checks = 0;
  int errors = 0;

  json_byte_unpacker #(.DATA_W(64), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_keep(in_keep),
    .in_last(in_last),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_byte(out_byte),
    .out_last(out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pkt_count(pkt_count),
    .err_empty_last(err_empty_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_b [5];
    logic [7:0] bp_b [8];
    int idx;
    logic rdy;

    rst = 1'b1; in_data = '0; in_keep = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick; tick;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_byte", 32'(out_byte), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_err", 32'(err_empty_last), 32'd0);
    rst = 1'b0;
    tick;

    // Single full beat
    in_data = 64'h0706050403020100; in_keep = 8'hFF; in_last = 1'b1; in_valid = 1'b1;
    #1;
    chk("full_accept_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("full_valid_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("full_byte_%0d", k), 32'(out_byte), 32'(k));
      chk($sformatf("full_last_%0d", k), 32'(out_last), 32'(k == 7));
      chk($sformatf("full_in_ready_%0d", k), 32'(in_ready), 32'(k == 7));
      tick;
    end
    chk("full_idle", 32'(out_valid), 32'd0);
    chk("full_pkt_count", 32'(pkt_count), 32'd1);

    // Back-to-back partial beats
    exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD; exp_b[4] = 8'hEE;
    in_data = 64'h11223344_55CCBBAA; in_keep = 8'h07; in_last = 1'b0; in_valid = 1'b1;
    tick;
    in_data = 64'h66778899_0011EEDD; in_keep = 8'h03; in_last = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("b2b_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("b2b_byte_%0d", i), 32'(out_byte), 32'(exp_b[i]));
      chk($sformatf("b2b_last_%0d", i), 32'(out_last), 32'(i == 4));
      if (i == 2) begin
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        #1;
      end else begin
        tick;
      end
    end
    chk("b2b_idle", 32'(out_valid), 32'd0);
    chk("b2b_pkt_count", 32'(pkt_count), 32'd2);

    // Backpressure: out_ready pattern 1,0,0 repeating
    bp_b[0] = 8'h11; bp_b[1] = 8'h22; bp_b[2] = 8'h33; bp_b[3] = 8'h44;
    bp_b[4] = 8'h55; bp_b[5] = 8'h66; bp_b[6] = 8'h77; bp_b[7] = 8'h88;
    in_data = 64'h8877665544332211; in_keep = 8'hFF; in_last = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
      rdy = ((cyc % 3) == 0);
      out_ready = rdy;
      #1;
      chk($sformatf("bp_valid_c%0d", cyc), 32'(out_valid), 32'd1);
      chk($sformatf("bp_byte_c%0d", cyc), 32'(out_byte), 32'(bp_b[idx]));
      chk($sformatf("bp_last_c%0d", cyc), 32'(out_last), 32'(idx == 7));
      chk($sformatf("bp_in_ready_c%0d", cyc), 32'(in_ready), 32'(idx == 7 && rdy));
      tick;
      if (rdy) idx++;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_bytes_done", 32'(idx), 32'd8);
    chk("bp_idle", 32'(out_valid), 32'd0);
    chk("bp_pkt_count", 32'(pkt_count), 32'd3);

    // Empty-last beat
    in_data = 64'hDEADBEEFDEADBEEF; in_keep = 8'h00; in_last = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    #1;
    chk("empty_no_output", 32'(out_valid), 32'd0);
    chk("empty_err_set", 32'(err_empty_last), 32'd1);
    chk("empty_pkt_count", 32'(pkt_count), 32'd3);
    chk("empty_in_ready", 32'(in_ready), 32'd1);
    tick; tick;
    chk("empty_err_sticky", 32'(err_empty_last), 32'd1);

    // Sparse keep 8'hA5
    in_data = 64'hF7E6D5C4B3A29180; in_keep = 8'hA5; in_last = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    #1;
`ifdef JSON_UNPACK_SPARSE_KEEP_EN
    exp_b[0] = 8'h80; exp_b[1] = 8'hA2; exp_b[2] = 8'hD5; exp_b[3] = 8'hF7;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sparse_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("sparse_byte_%0d", i), 32'(out_byte), 32'(exp_b[i]));
      chk($sformatf("sparse_last_%0d", i), 32'(out_last), 32'(i == 3));
      tick;
    end
`else
    chk("sparse_valid_0", 32'(out_valid), 32'd1);
    chk("sparse_byte_0", 32'(out_byte), 32'h80);
    chk("sparse_last_0", 32'(out_last), 32'd1);
    tick;
`endif
    chk("sparse_idle", 32'(out_valid), 32'd0);
    chk("sparse_pkt_count", 32'(pkt_count), 32'd4);

    // Reset mid-beat after 3 of 8 bytes
    in_data = 64'h0706050403020100; in_keep = 8'hFF; in_last = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_byte_%0d", k), 32'(out_byte), 32'(k));
      tick;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("mid_rst_err_cleared", 32'(err_empty_last), 32'd0);
    tick;
    chk("mid_rst_no_last", 32'(out_last), 32'd0);
    in_data = 64'h1716151413121110; in_keep = 8'h0F; in_last = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fresh_valid_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("fresh_byte_%0d", k), 32'(out_byte), 32'(8'h10 + k));
      chk($sformatf("fresh_last_%0d", k), 32'(out_last), 32'(k == 3));
      tick;
    end
    chk("fresh_idle", 32'(out_valid), 32'd0);
    chk("fresh_pkt_count", 32'(pkt_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/json_byte_unpacker.md
# json_byte_unpacker

- Downstream neighbour of the file-driven 64-bit stream source (`out_data`/`out_keep`/`out_last`).
- Accepts 64-bit beats with byte-keep and last via a valid/ready handshake.
- Serialises each beat into one byte per cycle, lane 0 first, and feeds the JSON tokenizer.
- Marks the final byte of each packet and keeps a packet counter and a protocol-error flag.

## Interface
Parameters:
- `DATA_W`, 64: input beat width; must be 64.
- `CNT_W`, 16: width of `pkt_count`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  64  beat data; lane i = `in_data[8i+7:8i]`.
- `in_keep`  in  8  lane-valid mask; bit i qualifies lane i.
- `in_last`  in  1  beat ends a packet.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `out_byte`  out  8  serialised byte.
- `out_last`  out  1  final byte of a packet.
- `out_valid`  out  1  byte present.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `pkt_count`  out  CNT_W  packets completed (byte with `out_last` handshaken); wraps modulo 2^CNT_W.
- `err_empty_last`  out  1  sticky; set when a beat with `in_last=1` carries no emittable lanes.

## Operation
- Internal beat register holds:
  - `data` (64 bits);
  - `mask` (8 bits): lanes still to emit;
  - `last` (1 bit).
- FSM has two states:
  - **EMPTY**:
    - `out_valid=0`, `in_ready=1`.
    - On accept:
      - `mask` ← emittable lanes of `in_keep`.
      - If `mask` ≠ 0: → DRAIN.
      - If `mask` = 0: stay EMPTY, beat discarded; if `in_last=1`, set `err_empty_last`.
  - **DRAIN**:
    - `out_valid=1`.
    - `out_byte` = lane at the lowest set bit of `mask`.
    - `out_last` = `last` && exactly one bit of `mask` set.
    - On output handshake, that bit is cleared from `mask`.
- Final-byte handshake in DRAIN (one `mask` bit set, `out_ready=1`):
  - `in_ready=1` in the same cycle. `in_ready` is combinational from `out_ready` and state.
  - If a new beat is accepted, load it and go to DRAIN, or to EMPTY if its `mask`=0.
  - If no beat is accepted: → EMPTY.
- `in_ready=0` in DRAIN at all other times.
- `pkt_count` increments on every handshaken byte with `out_last=1`.
- Outputs `out_byte`/`out_last` are held stable while `out_valid && !out_ready`.
- Reset:
  - State → EMPTY; `data`, `mask`, `last` → 0.
  - `pkt_count` → 0; `err_empty_last` → 0.
  - Resulting output values: `out_valid=0`, `out_byte=0`, `out_last=0`, `in_ready=1` (evaluated with `rst` high too).
- Reset mid-packet: the buffered beat is dropped; no partial `out_last` is emitted.

## Timing
- Latency: beat accepted at edge N → its first byte has `out_valid=1` in the cycle after edge N.
- Throughput: one byte per cycle when `out_ready=1`.
  - A full 8-lane beat occupies 8 cycles.
  - Back-to-back beats have no bubble.
- A `mask`=0 beat costs one cycle in EMPTY and produces no output.
- Upstream must hold beat fields stable while `in_valid && !in_ready`.
- `out_ready` may toggle arbitrarily; stalls add cycles one-for-one.

## Configuration
- Macro: `JSON_UNPACK_SPARSE_KEEP_EN`.
- **Defined:**
  - Emittable lanes = every lane with `in_keep` bit set, in ascending order; holes are skipped.
  - Example: `in_keep=8'b1010_0101` emits lanes 0, 2, 5, 7.
- **Undefined:**
  - Emittable lanes = the contiguous run of set bits starting at lane 0; lanes at and above the first zero bit are ignored.
  - Example: `8'b1010_0101` emits lane 0 only; `8'b1111_1110` emits nothing.

## Test plan
- **Single full beat:**
  - Stimulus: reset; then beat `in_data=64'h0706050403020100`, `in_keep=8'hFF`, `in_last=1`; `out_ready=1`.
  - Response: bytes 00..07 on 8 consecutive cycles starting the cycle after accept; `out_last` only on 07; `pkt_count=1`; `in_ready` high in the 07 cycle.
- **Back-to-back partial beats:**
  - Stimulus: beat A `in_keep=8'h07`, `in_last=0`; beat B `in_keep=8'h03`, `in_last=1`; `in_valid` held high.
  - Response: 5 bytes with no gaps; `out_last` on the 5th byte only; `pkt_count=1`.
- **Backpressure:**
  - Stimulus: `out_ready` toggles 1,0,0,1,… during a full beat.
  - Response: `out_byte` and `out_last` stable through the stall cycles; no byte lost or duplicated; `in_ready=0` until the final byte handshakes.
- **Empty-last beat:**
  - Stimulus: `in_keep=8'h00`, `in_last=1`.
  - Response: no output; `err_empty_last=1` and stays 1; `pkt_count` unchanged; a reset clears the flag.
- **Sparse keep:**
  - Stimulus: `in_keep=8'hA5`.
  - Response with macro defined: lanes 0, 2, 5, 7 emitted.
  - Response without macro: lane 0 only.
- **Reset mid-beat:**
  - Stimulus: assert `rst` after 3 of 8 bytes.
  - Response: next cycle `out_valid=0` and `in_ready=1`; `pkt_count=0`; a fresh beat then serialises normally from lane 0.
